seq_signed_mult_param: RTL
==========================

Name: seq_signed_mult_param

Overview:
Parametrised successor to the fixed 8-bit sequential signed multiplier. It multiplies two WIDTH-bit two's-complement operands by shift-and-add on magnitudes, then applies the sign. It uses a start/busy/done handshake and supplies both a two's-complement product and a sign-magnitude product. It sits between the push-button/control path and the BCD/seven-segment display path, and replaces the separate ctrl_unit and datapath pair.

Parameters:
WIDTH, 8, operand width in bits (legal values 2 to 16)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override)

Ports:
sys_clk  input  1  system clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; sampled only while busy=0
multiplier  input  WIDTH  signed operand A
multiplicand  input  WIDTH  signed operand B; its bits are scanned for shift-add
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when the result becomes valid
product  output  2*WIDTH  signed product A*B, two's complement
product_mag  output  2*WIDTH-1  |A*B|, unsigned
sign  output  1  1 only when the product is negative and nonzero
iter_count  output  CNT_W  number of RUN iterations used by the last operation

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state=IDLE.
  - busy, done, sign, product, product_mag and iter_count all 0.
  - Internal accumulator and shift registers cleared.
- States: IDLE, RUN.
- IDLE, on the edge where start=1 (call it edge k):
  - Latch magA=|multiplier| and magB=|multiplicand|, each as WIDTH-bit unsigned. The most negative value (-2^(WIDTH-1)) maps to 2^(WIDTH-1) with no overflow.
  - Latch neg = multiplier[MSB] ^ multiplicand[MSB].
  - Clear accumulator and counter, set busy=1, go to RUN.
  - done is driven 0 on this edge.
- RUN, one iteration per edge:
  - If magB[0]=1, acc <= acc + mA, where mA is magA shifted left by the count, 2*WIDTH-1 bits wide.
  - Then mA <<= 1, magB >>= 1, counter += 1.
- Terminating edge: the iteration edge where counter reaches WIDTH (or the early-termination condition under the optional feature). On that edge:
  - The final accumulator value is used, including that edge's addition.
  - product_mag <= final acc.
  - sign <= neg AND (final acc != 0).
  - product <= sign ? -acc : acc, sign-extended to 2*WIDTH bits.
  - iter_count <= counter + 1.
  - busy <= 0, done <= 1 for exactly one cycle, state <= IDLE.
- Latency: done is high in the cycle after edge k+N, where N is the number of RUN iterations.
  - Without the optional feature, N=WIDTH.
- Results hold until the next terminating edge or reset. They do not change on a new start until that operation completes.
- start while busy=1 is ignored; it is neither queued nor restarting.
- start in the same cycle as the done pulse (state IDLE) is accepted normally; results from the previous operation remain visible until the new operation finishes.
- Width rules:
  - Maximum magnitude is 2^(2*WIDTH-2), which fits product_mag.
  - product is exact for all operand pairs; there is no overflow flag.
- Zero result: sign=0 and product=0 regardless of operand signs. The display path never shows "-0".

Optional Feature:
EARLY_TERM_EN
- Defined: RUN terminates on the first iteration edge after which the shifted magB is zero, or when counter reaches WIDTH, whichever comes first.
  - N = max(1, index of the highest set bit of |multiplicand| + 1).
  - multiplicand=0 gives N=1.
  - iter_count reports N.
- Not defined: N=WIDTH always and iter_count=WIDTH always.
- Arithmetic results are identical in both builds.

Test Plan:
1. WIDTH=8: A=5, B=-3, pulse start -> done after N cycles; product=-15 (16'hFFF1), product_mag=15, sign=1. N=8, or N=2 with EARLY_TERM_EN.
2. A=-128, B=-128 -> product=16384, product_mag=16384, sign=0. N=8 in both builds.
3. A=-7, B=0 -> product=0, product_mag=0, sign=0, done pulses exactly one cycle. N=1 with EARLY_TERM_EN, else 8.
4. A=3, B=4, then a second start pulse on cycle 2 of RUN with A=9, B=9 -> second start ignored; result 12; busy stays continuously high; exactly one done pulse.
5. Start A=100, B=-100; assert rst on the 4th RUN cycle -> all outputs 0 asynchronously (before the next clock edge); state IDLE. A following start with A=-1, B=1 -> product=-1 (16'hFFFF), sign=1.
6. Back-to-back: start asserted in the done cycle with A=127, B=127 -> accepted; previous product still visible while busy; then product=16129 and iter_count=7 with EARLY_TERM_EN.

Source files
------------

// File: rtl/seq_signed_mult_param.sv
// ---------------------------------------------------------------------------
// seq_signed_mult_param
//
// Sequential signed multiplier. Both operands are reduced to magnitudes,
// multiplied by shift-and-add (one multiplicand bit per clock), and the sign
// is applied at the end. A start/busy/done handshake controls the operation.
// Two's-complement and sign-magnitude forms of the product are both provided.
//
// Optional build macro: EARLY_TERM_EN
//   When defined, RUN stops as soon as the remaining multiplicand bits are
//   all zero. Arithmetic results are identical in both builds; only the
//   latency and iter_count differ.
//
// Ports:
//   sys_clk      in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   one-cycle request, sampled only while idle
//   multiplier   in   WIDTH-bit signed operand A
//   multiplicand in   WIDTH-bit signed operand B (scanned bit by bit)
//   busy         out  high while an operation is in progress
//   done         out  one-cycle pulse when the results update
//   product      out  2*WIDTH-bit signed product A*B
//   product_mag  out  2*WIDTH-1-bit unsigned |A*B|
//   sign         out  1 only for a negative, nonzero product
//   iter_count   out  RUN iterations used by the last operation
// ---------------------------------------------------------------------------
module seq_signed_mult_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [2*WIDTH-2:0]   product_mag,
    output logic                 sign,
    output logic [CNT_W-1:0]     iter_count
);

    // The largest magnitude, 2^(2*WIDTH-2), needs exactly 2*WIDTH-1 bits.
    localparam int PW = 2 * WIDTH - 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state_reg, state_next;

    logic [PW-1:0]    ma_reg;     // magnitude of A, pre-shifted by the count
    logic [PW-1:0]    acc_reg;    // partial magnitude sum
    logic [WIDTH-1:0] mb_reg;     // magnitude of B, shifted right each step
    logic [CNT_W-1:0] cnt_reg;
    logic             neg_reg;

    logic               busy_reg;
    logic               done_reg;
    logic [2*WIDTH-1:0] product_reg;
    logic [PW-1:0]      product_mag_reg;
    logic               sign_reg;
    logic [CNT_W-1:0]   iter_count_reg;

    // Control strobes from the FSM
    logic load;
    logic step;
    logic finish;

    // Operand magnitudes. Negating -2^(WIDTH-1) in WIDTH bits yields the same
    // bit pattern, which read as unsigned is exactly 2^(WIDTH-1).
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [PW-1:0]      acc_sum;
    logic [CNT_W-1:0]   cnt_inc;
    logic               last_iter;
    logic               final_zero;
    logic               final_sign;
    logic [2*WIDTH-1:0] final_product;

    always_comb begin
        mag_a = multiplier[WIDTH-1]   ? (-multiplier)   : multiplier;
        mag_b = multiplicand[WIDTH-1] ? (-multiplicand) : multiplicand;
    end

    // This step's addition is folded in combinationally so the terminating
    // edge can publish the final sum directly.
    always_comb begin
        acc_sum       = acc_reg + (mb_reg[0] ? ma_reg : '0);
        cnt_inc       = cnt_reg + CNT_W'(1);
        final_zero    = (acc_sum == '0);
        final_sign    = neg_reg & ~final_zero;
        final_product = final_sign ? (-{1'b0, acc_sum}) : {1'b0, acc_sum};
    end

`ifdef EARLY_TERM_EN
    // Stop once no set bits of B remain above the one consumed this step.
    always_comb begin
        last_iter = (cnt_reg == CNT_W'(WIDTH - 1)) || (mb_reg[WIDTH-1:1] == '0);
    end
`else
    always_comb begin
        last_iter = (cnt_reg == CNT_W'(WIDTH - 1));
    end
`endif

    // FSM state register
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state and control strobes
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last_iter) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            ma_reg          <= '0;
            acc_reg         <= '0;
            mb_reg          <= '0;
            cnt_reg         <= '0;
            neg_reg         <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            product_reg     <= '0;
            product_mag_reg <= '0;
            sign_reg        <= 1'b0;
            iter_count_reg  <= '0;
        end else begin
            done_reg <= finish;
            if (load) begin
                ma_reg   <= {{(PW - WIDTH){1'b0}}, mag_a};
                mb_reg   <= mag_b;
                acc_reg  <= '0;
                cnt_reg  <= '0;
                neg_reg  <= multiplier[WIDTH-1] ^ multiplicand[WIDTH-1];
                busy_reg <= 1'b1;
            end else if (step) begin
                acc_reg <= acc_sum;
                ma_reg  <= ma_reg << 1;
                mb_reg  <= mb_reg >> 1;
                cnt_reg <= cnt_inc;
                if (finish) begin
                    busy_reg        <= 1'b0;
                    product_mag_reg <= acc_sum;
                    sign_reg        <= final_sign;
                    product_reg     <= final_product;
                    iter_count_reg  <= cnt_inc;
                end
            end
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign product     = product_reg;
    assign product_mag = product_mag_reg;
    assign sign        = sign_reg;
    assign iter_count  = iter_count_reg;

endmodule
